// File: rtl/uart_rx_fifo_pkg.sv
// Shared register map, bit positions and helpers for the UART receive FIFO.
// Used by the FIFO top, its storage array and the MMIO mapper side.
package uart_rx_fifo_pkg;

  localparam int RXF_BYTE_W = 8;

  typedef enum logic [2:0] {
    RXF_DATA = 3'd0,
    RXF_STAT = 3'd1,
    RXF_CTRL = 3'd2
  } rxf_reg_e;

  localparam int RXF_VALID_BIT  = 8;
  localparam int RXF_EMPTY_BIT  = 16;
  localparam int RXF_FULL_BIT   = 17;
  localparam int RXF_OVF_BIT    = 18;
  localparam int RXF_TMO_BIT    = 19;
  localparam int RXF_IRQEN_BIT  = 0;
  localparam int RXF_THRESH_LSB = 8;
  localparam int RXF_THRESH_W   = 5;
  localparam int RXF_FLUSH_BIT  = 31;

  // A threshold of zero would keep irq asserted on an empty FIFO, so it acts as one.
  function automatic logic [RXF_THRESH_W-1:0] rxf_eff_thresh(input logic [RXF_THRESH_W-1:0] thresh);
    return (thresh == '0) ? RXF_THRESH_W'(1) : thresh;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO (rxfifo_mem): synchronous write, asynchronous
// read, intended to map onto distributed RAM. Contents are never reset.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [RXF_BYTE_W-1:0] i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [RXF_BYTE_W-1:0] o_rdata
);

  logic [RXF_BYTE_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART core and the CPU bus, with MMIO registers and a level irq.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout flag (STAT.tmo); otherwise tmo reads 0.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 62500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxnew,
  input  logic [7:0]  rxdata,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        irq
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    r_ovf;
  logic                    r_irq_en;
  logic [RXF_THRESH_W-1:0] r_thresh;
  logic                    r_irq;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_flush;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_ovf_set;
  logic                    w_ovf_clr;
  logic                    w_ctrl_we;
  logic                    w_tmo;
  logic [RXF_BYTE_W-1:0]   w_head;
  logic                    w_unused_d;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_COUNT);
  assign w_ctrl_we = we && (a == RXF_CTRL);
  assign w_flush   = w_ctrl_we && d[RXF_FLUSH_BIT];
  assign w_pop     = rd && (a == RXF_DATA) && !w_empty && !w_flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push    = rxnew && (!w_full || w_pop) && !w_flush;
  assign w_ovf_set = rxnew && w_full && !w_pop && !w_flush;
  assign w_ovf_clr = we && (a == RXF_STAT) && d[RXF_OVF_BIT];
  assign w_unused_d = ^{d[30:19], d[17:13], d[7:1]};

  uart_rx_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (rxdata),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new overflow outranks a same-cycle software clear so no drop goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_thresh <= RXF_THRESH_W'(1);
    end else if (w_ctrl_we) begin
      r_irq_en <= d[RXF_IRQEN_BIT];
      r_thresh <= d[RXF_THRESH_LSB +: RXF_THRESH_W];
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] r_idle;
  logic              r_tmo;

  // Idle time is counted only while bytes wait; any FIFO activity restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (w_push || w_pop || w_flush) begin
        r_idle <= '0;
      end else if (!w_empty && (r_idle != IDLE_MAX)) begin
        r_idle <= r_idle + 1'b1;
      end
      if (w_pop || w_flush) begin
        r_tmo <= 1'b0;
      end else if (r_idle == IDLE_MAX) begin
        r_tmo <= 1'b1;
      end
    end
  end

  assign w_tmo = r_tmo;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en &&
               ((32'(r_count) >= 32'(rxf_eff_thresh(r_thresh))) || w_tmo);
    end
  end

  assign irq = r_irq;

  always_comb begin
    spo = '0;
    case (a)
      RXF_DATA: begin
        if (!w_empty) begin
          spo[RXF_VALID_BIT] = 1'b1;
          spo[7:0]           = w_head;
        end
      end
      RXF_STAT: begin
        spo[DEPTH_LOG2:0]  = r_count;
        spo[RXF_EMPTY_BIT] = w_empty;
        spo[RXF_FULL_BIT]  = w_full;
        spo[RXF_OVF_BIT]   = r_ovf;
        spo[RXF_TMO_BIT]   = w_tmo;
      end
      RXF_CTRL: begin
        spo[RXF_IRQEN_BIT]                   = r_irq_en;
        spo[RXF_THRESH_LSB +: RXF_THRESH_W]  = r_thresh;
      end
      default: spo = '0;
    endcase
  end

endmodule
